// File: rtl/divide_sequencer.sv
// Sequential 16/8 unsigned divider using a reciprocal-multiply with optional exact correction.
// Optional feature macro: DIVIDE_SEQUENCER_CORRECT_EN (adds CORR state and remainder output).
module divide_sequencer #(
    parameter logic [15:0] ERR_QUOT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_err
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] MUL   = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] CORR  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]  state;
    logic [31:0] product;
    logic [31:0] mcand;
    logic [15:0] mul_r;
    logic [4:0]  shift_r;
    logic [3:0]  cnt;
    logic [15:0] q_shift;

    logic        tbl_ok;
    logic [15:0] tbl_mul;
    logic [4:0]  tbl_shift;

    // Reciprocal table: powers of two are a pure shift, others round(65536/d) >> 16
    always_comb begin
        tbl_ok    = 1'b1;
        tbl_mul   = 16'd1;
        tbl_shift = 5'd16;
        case (divisor)
            8'd1:  tbl_shift = 5'd0;
            8'd2:  tbl_shift = 5'd1;
            8'd4:  tbl_shift = 5'd2;
            8'd8:  tbl_shift = 5'd3;
            8'd16: tbl_shift = 5'd4;
            8'd3:  tbl_mul = 16'd21845;
            8'd5:  tbl_mul = 16'd13107;
            8'd6:  tbl_mul = 16'd10923;
            8'd7:  tbl_mul = 16'd9362;
            8'd9:  tbl_mul = 16'd7282;
            8'd10: tbl_mul = 16'd6554;
            8'd11: tbl_mul = 16'd5958;
            8'd12: tbl_mul = 16'd5461;
            8'd13: tbl_mul = 16'd5041;
            8'd14: tbl_mul = 16'd4681;
            8'd15: tbl_mul = 16'd4369;
            8'd17: tbl_mul = 16'd3855;
            8'd18: tbl_mul = 16'd3641;
            8'd19: tbl_mul = 16'd3449;
            8'd20: tbl_mul = 16'd3277;
            8'd21: tbl_mul = 16'd3121;
            8'd22: tbl_mul = 16'd2979;
            8'd23: tbl_mul = 16'd2849;
            8'd24: tbl_mul = 16'd2731;
            8'd25: tbl_mul = 16'd2621;
            8'd26: tbl_mul = 16'd2521;
            8'd27: tbl_mul = 16'd2427;
            8'd28: tbl_mul = 16'd2341;
            8'd29: tbl_mul = 16'd2260;
            8'd30: tbl_mul = 16'd2185;
            default: begin
                tbl_ok    = 1'b0;
                tbl_mul   = 16'd0;
                tbl_shift = 5'd0;
            end
        endcase
    end

    assign q_shift  = 16'(product >> shift_r);
    assign in_ready = (state == IDLE);

`ifdef DIVIDE_SEQUENCER_CORRECT_EN
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [15:0] q_raw;
    logic [23:0] qd;
    logic [25:0] r_s;
    logic        r_neg;
    logic        r_big;

    // Raw estimate is within one of exact, so r lands in [-d, 2d)
    assign qd    = {8'd0, q_raw} * {16'd0, dvs};
    assign r_s   = {10'd0, dvd} - {2'd0, qd};
    assign r_neg = r_s[25];
    assign r_big = !r_neg && (r_s >= {18'd0, dvs});
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            quotient  <= 16'd0;
            remainder <= 8'd0;
            div_err   <= 1'b0;
            product   <= 32'd0;
            mcand     <= 32'd0;
            mul_r     <= 16'd0;
            shift_r   <= 5'd0;
            cnt       <= 4'd0;
`ifdef DIVIDE_SEQUENCER_CORRECT_EN
            dvd       <= 16'd0;
            dvs       <= 8'd0;
            q_raw     <= 16'd0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (tbl_ok) begin
                        mcand   <= {16'd0, dividend};
                        mul_r   <= tbl_mul;
                        shift_r <= tbl_shift;
                        product <= 32'd0;
                        cnt     <= 4'd0;
`ifdef DIVIDE_SEQUENCER_CORRECT_EN
                        dvd     <= dividend;
                        dvs     <= divisor;
`endif
                        state   <= MUL;
                    end else begin
                        quotient  <= ERR_QUOT;
                        remainder <= 8'd0;
                        div_err   <= 1'b1;
                        state     <= DONE;
                    end
                end
                MUL: begin
                    if (mul_r[0]) product <= product + mcand;
                    mcand <= mcand << 1;
                    mul_r <= mul_r >> 1;
                    cnt   <= cnt + 4'd1;
                    if (cnt == 4'd15) state <= SHIFT;
                end
                SHIFT: begin
`ifdef DIVIDE_SEQUENCER_CORRECT_EN
                    q_raw <= q_shift;
                    state <= CORR;
`else
                    quotient  <= q_shift;
                    remainder <= 8'd0;
                    div_err   <= 1'b0;
                    state     <= DONE;
`endif
                end
`ifdef DIVIDE_SEQUENCER_CORRECT_EN
                CORR: begin
                    if (r_neg) begin
                        quotient  <= q_raw - 16'd1;
                        remainder <= r_s[7:0] + dvs;
                    end else if (r_big) begin
                        quotient  <= q_raw + 16'd1;
                        remainder <= r_s[7:0] - dvs;
                    end else begin
                        quotient  <= q_raw;
                        remainder <= r_s[7:0];
                    end
                    div_err <= 1'b0;
                    state   <= DONE;
                end
`endif
                // Results are loaded on entry; out_valid rises one edge later
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/divide_sequencer.md
DIVIDE_SEQUENCER -- requirements
Module: divide_sequencer

Interface
REQ-001 Parameter: ERR_QUOT, default 16'hFFFF, quotient returned for an unsupported divisor.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 dividend  input  16  unsigned dividend.
REQ-007 divisor  input  8  unsigned divisor; supported range 1..30.
REQ-008 out_valid  output  1  result present.
REQ-009 out_ready  input  1  consumer takes result.
REQ-010 quotient  output  16  unsigned quotient.
REQ-011 remainder  output  8  unsigned remainder.
REQ-012 div_err  output  1  result is for an unsupported divisor (0 or >30).

Function
REQ-013 The block SHALL hold an internal reciprocal table: for divisor d that is a power of two (1,2,4,8,16), mul=1 and shift=log2(d); for other d in 3..30, mul=round-to-nearest(65536/d) and shift=16.
REQ-014 The FSM SHALL have states IDLE, MUL, SHIFT, CORR, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 A request SHALL be accepted on an edge where in_valid=1 and in_ready=1; dividend and divisor SHALL be registered then, and later input changes ignored.
REQ-016 Supported divisor: IDLE->MUL; MUL SHALL run exactly 16 cycles of shift-add (one multiplier bit per cycle, LSB first) into a 32-bit product register.
REQ-017 SHIFT (1 cycle) SHALL form raw quotient q = product >> shift, truncated to 16 bits.
REQ-018 CORR (1 cycle) SHALL compute signed r = dividend - q*d; if r<0: q=q-1, r=r+d; else if r>=d: q=q+1, r=r-d; otherwise unchanged; then ->DONE.
REQ-019 With correction, out_valid SHALL assert on the 19th rising edge after the accepting edge; quotient and remainder SHALL equal exact floor division results.
REQ-020 Unsupported divisor: IDLE->DONE directly; out_valid asserts on the first edge after acceptance with quotient=ERR_QUOT, remainder=0, div_err=1.
REQ-021 div_err SHALL be 0 for every supported-divisor result.
REQ-022 In DONE, out_valid=1 and quotient/remainder/div_err SHALL stay stable until an edge with out_ready=1, which SHALL move the FSM to IDLE and clear out_valid.
REQ-023 No request SHALL be accepted on the same edge a result is consumed; the earliest next accept is the following edge.
REQ-024 out_ready SHALL be ignored in every state except DONE.

Reset
REQ-025 reset_n=0 SHALL asynchronously force IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_err=0, and clear the product register.
REQ-026 Reset asserted mid-operation (MUL/SHIFT/CORR/DONE) SHALL abandon the request with no result emitted.
REQ-027 After reset_n deasserts, the first request SHALL be accepted on the first edge with in_valid=1.

Configuration
REQ-028 Macro DIVIDE_SEQUENCER_CORRECT_EN SHALL compile in the CORR state and remainder logic.
REQ-029 With DIVIDE_SEQUENCER_CORRECT_EN defined: behaviour per REQ-018/019.
REQ-030 Without it: SHIFT SHALL go directly to DONE, quotient = raw q (may be exact result +/-1), remainder tied to 0, supported-divisor latency 18 edges; error path unchanged.

Verification
REQ-031 100/7, out_ready=1 -> quotient=14, remainder=2, div_err=0, out_valid on edge 19 after accept.
REQ-032 65535/3 -> quotient=21845, remainder=0 (raw 21844 corrected up); without macro quotient=21844.
REQ-033 65531/6 -> quotient=10921, remainder=5 (raw 10922 corrected down).
REQ-034 1234/0 and 1234/31 -> quotient=16'hFFFF, remainder=0, div_err=1, out_valid one edge after accept.
REQ-035 500/16 with out_ready=0 for 5 cycles -> quotient=31, remainder=4 held stable, in_ready=0 throughout, IDLE one edge after out_ready=1.
REQ-036 reset_n pulsed low during MUL cycle 8 -> all outputs to reset values, no result; then 40/8 -> quotient=5, remainder=0.
